// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the MAC dot-product sequencer.
// Saturation limits are derived from the psum width by helper functions.
package mac_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int DEF_BW      = 4;
    localparam int DEF_PSUM_BW = 16;
    localparam int DEF_LEN_BW  = 4;

    // Width of the product/sum after sign extension of the unsigned activation
    function automatic int prod_w(input int w);
        return 2 * w + 1;
    endfunction

    function automatic int sum_w(input int w);
        return w + 1;
    endfunction

    // Largest positive value of a w-bit signed number, as a 64-bit pattern
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative value of a w-bit signed number, low w bits significant
    function automatic logic [63:0] sat_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/mac_seq_ctrl_mac_step.sv
// Combinational MAC step: unsigned activation x signed weight + psum.
// Result is one bit wider than psum so the caller can detect overflow.
module mac_step
    import mac_seq_pkg::*;
#(
    parameter int bw      = DEF_BW,
    parameter int psum_bw = DEF_PSUM_BW
) (
    input  logic        [bw-1:0]    i_a,
    input  logic        [bw-1:0]    i_b,
    input  logic signed [psum_bw-1:0] i_psum,
    output logic signed [psum_bw:0] o_sum
);

    localparam int PW = prod_w(bw);
    localparam int SW = sum_w(psum_bw);

    logic signed [bw:0]     w_a_s;
    logic signed [bw-1:0]   w_b_s;
    logic signed [PW-1:0]   w_prod;

    assign w_a_s  = signed'({1'b0, i_a});
    assign w_b_s  = signed'(i_b);
    assign w_prod = PW'(w_a_s) * PW'(w_b_s);
    assign o_sum  = SW'(i_psum) + SW'(w_prod);

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer around a single MAC step with valid/ready I/O.
// Define MAC_SEQ_SAT_EN to clamp psum on overflow instead of wrapping.
module mac_seq_ctrl
    import mac_seq_pkg::*;
#(
    parameter int bw      = DEF_BW,
    parameter int psum_bw = DEF_PSUM_BW,
    parameter int len_bw  = DEF_LEN_BW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [len_bw-1:0]  len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [bw-1:0]      a,
    input  logic [bw-1:0]      b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [psum_bw-1:0] out,
    output logic               busy,
    output logic               ovf
);

    state_t                    r_state;
    logic [len_bw-1:0]         r_len;
    logic [len_bw-1:0]         r_cnt;
    logic signed [psum_bw-1:0] r_psum;
    logic                      r_ovf;

    logic signed [psum_bw:0]   w_sum;
    logic                      w_of;
    logic [psum_bw-1:0]        w_next;
    logic                      w_last;

    mac_step #(
        .bw      (bw),
        .psum_bw (psum_bw)
    ) u_step (
        .i_a    (a),
        .i_b    (b),
        .i_psum (r_psum),
        .o_sum  (w_sum)
    );

    // Top two sum bits disagree when the result left the signed psum range
    assign w_of   = w_sum[psum_bw] ^ w_sum[psum_bw-1];
    assign w_last = (r_cnt == r_len - len_bw'(1));

`ifdef MAC_SEQ_SAT_EN
    localparam logic [psum_bw-1:0] SAT_MAX = psum_bw'(sat_max(psum_bw));
    localparam logic [psum_bw-1:0] SAT_MIN = psum_bw'(sat_min(psum_bw));

    // Clamp toward the true sign (the extra sum bit) on overflow
    always_comb begin
        w_next = w_sum[psum_bw-1:0];
        if (w_of) begin
            w_next = w_sum[psum_bw] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign w_next = w_sum[psum_bw-1:0];
`endif

    // Sequencer FSM owning psum, term count, latched length and overflow flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_cnt   <= '0;
            r_psum  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_psum <= '0;
                        r_cnt  <= '0;
                        r_ovf  <= 1'b0;
                        if (len != '0) begin
                            r_len   <= len;
                            r_state <= S_RUN;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    if (in_valid) begin
                        r_psum <= w_next;
                        r_cnt  <= r_cnt + len_bw'(1);
                        if (w_of) begin
                            r_ovf <= 1'b1;
                        end
                        if (w_last) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_RUN);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign out       = r_psum;
    assign ovf       = r_ovf;

endmodule
